mdr_mem_port: RTL and testbench

Memory Data Register with the bus-receiving side and the memory handshake. It captures words from the shared datapath bus, or fetches them from memory through a request/acknowledge handshake, and holds the value for the bus-driving register stage. It sits between the internal bus and the memory interface, opposite the bus-driving registers. It is the receiving end of the bus, complementing the registers that drive it.

---
 rtl/mdr_pkg.sv | 15 +
 rtl/mdr_timeout_ctr.sv | 35 +++
 rtl/mdr_mem_port.sv | 116 +++++++++++
 tb/tb_mdr_mem_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and default constants for the memory data register port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdr_pkg;

  localparam int MDR_WIDTH   = 32;
  localparam int MDR_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_t;

endpackage

// File: rtl/mdr_timeout_ctr.sv
// Wait-cycle counter: clears outside a transfer, counts unacked wait cycles, flags expiry.
// Latency: expire is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; the owner decides whether an ack in the same cycle overrides expiry.
module mdr_timeout_ctr
  import mdr_pkg::*;
#(
  parameter int TIMEOUT = MDR_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  // The count only ever holds 0..TIMEOUT-1; the increment that would land on
  // TIMEOUT is reported as expiry instead of being stored.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expire = inc && (cnt == CW'(TIMEOUT - 1));

  // Clear on idle or expiry, otherwise step once per unacked wait cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register: loads from the datapath bus or runs a req/ack memory read/write.
// Latency: bus load 1 cycle; memory transfer N+1 .. ack edge, done the cycle after the ack.
// Backpressure: commands are dropped while busy; optional abort when MDR_TIMEOUT_EN is defined.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int WIDTH   = MDR_WIDTH,
  parameter int TIMEOUT = MDR_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             mdr_in,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic             mem_ack,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic [WIDTH-1:0] mem_data_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  mdr_state_t state;
  logic       in_wait;
  logic       expire;

  assign in_wait      = (state == RD_WAIT) || (state == WR_WAIT);
  assign mem_data_out = q;

`ifdef MDR_TIMEOUT_EN
  mdr_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_wait),
    .inc   (in_wait && !mem_ack),
    .expire(expire)
  );
`else
  // Without the timeout feature a transfer waits for its ack forever.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign expire             = 1'b0;
`endif

  // Control FSM with all outputs registered; an ack always beats expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      q          <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // read > write > bus load; lower-priority requests are dropped.
          if (read) begin
            state      <= RD_WAIT;
            mem_rd_req <= 1'b1;
            busy       <= 1'b1;
          end else if (write) begin
            state      <= WR_WAIT;
            mem_wr_req <= 1'b1;
            busy       <= 1'b1;
          end else if (mdr_in) begin
            q <= bus_in;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            q          <= mem_data_in;
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else if (expire) begin
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_wr_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else if (expire) begin
            mem_wr_req <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          mem_rd_req <= 1'b0;
          mem_wr_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_port.sv
// Bench for mdr_mem_port: vector table of loads/transfers plus hand-written corner sequences.
// Latency: expected q values are queued at command time and retired on each done pulse.
// Backpressure: covers dropped commands while busy, ack in idle, reset mid-transfer, timeout.
module tb_mdr_mem_port;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] bus_in;
  logic         mdr_in;
  logic         read;
  logic         write;
  logic [W-1:0] mem_data_in;
  logic         mem_ack;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [W-1:0] mem_data_out;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic         err;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] model_q = '0;
  logic [W-1:0] sb[$];

  mdr_mem_port #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_in      (bus_in),
    .mdr_in      (mdr_in),
    .read        (read),
    .write       (write),
    .mem_data_in (mem_data_in),
    .mem_ack     (mem_ack),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_data_out(mem_data_out),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           op;     // 0 = bus load, 1 = memory read, 2 = memory write
    logic [W-1:0] data;
    int           delay;  // cycles mem_ack is held off
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire one scoreboard entry on the done pulse, then confirm it lasts one cycle.
  task automatic wait_done(input int bound);
    logic [W-1:0] e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: done seen with no transfer pending");
        end else begin
          e = sb.pop_front();
          check("sb_q", q, e);
          check("done_rd_req", 32'(mem_rd_req), 32'd0);
          check("done_wr_req", 32'(mem_wr_req), 32'd0);
          check("done_busy", 32'(busy), 32'd0);
          check("done_err", 32'(err), 32'd0);
        end
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", bound);
    end
    step();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    step();
  endtask

  task automatic do_load(input logic [W-1:0] data);
    bus_in = data;
    mdr_in = 1'b1;
    step();
    mdr_in = 1'b0;
    bus_in = ~data;
    @(negedge clk);
    check("load_q", q, data);
    check("load_busy", 32'(busy), 32'd0);
    check("load_done", 32'(done), 32'd0);
    check("load_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    model_q = data;
    step();
  endtask

  task automatic do_xfer(input bit is_rd, input logic [W-1:0] data, input int delay);
    logic [W-1:0] exp_q;
    int hi;
    int errs;
    exp_q = is_rd ? data : model_q;
    sb.push_back(exp_q);
    if (is_rd) read = 1'b1;
    else write = 1'b1;
    step();
    read  = 1'b0;
    write = 1'b0;
    hi    = 0;
    errs  = 0;
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        mem_ack     = 1'b1;
        mem_data_in = is_rd ? data : ~model_q;
      end
      @(negedge clk);
      if (is_rd ? mem_rd_req : mem_wr_req) hi++;
      if (err) errs++;
      if (is_rd ? mem_wr_req : mem_rd_req) begin
        total++;
        bad++;
        $display("FAIL wrong_req: other request high at wait cycle %0d", i);
      end
      if (!is_rd && i == 0) check("wr_data_out", mem_data_out, model_q);
      step();
    end
    mem_ack     = 1'b0;
    mem_data_in = '0;
    check(is_rd ? "rd_req_cycles" : "wr_req_cycles", 32'(hi), 32'(delay + 1));
    check("xfer_err", 32'(errs), 32'd0);
    wait_done(4);
    model_q = exp_q;
  endtask

  initial begin
    vecs[0] = '{0, 32'hDEADBEEF, 0};
    vecs[1] = '{1, 32'h12345678, 3};
    vecs[2] = '{0, 32'hA5A5A5A5, 0};
    vecs[3] = '{2, 32'h0, 0};
    vecs[4] = '{1, 32'hCAFEF00D, 0};
    vecs[5] = '{2, 32'h0, 2};

    reset = 1'b0; bus_in = '0; mdr_in = 1'b0; read = 1'b0; write = 1'b0;
    mem_data_in = '0; mem_ack = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_q", q, 32'd0);
    check("rst_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    check("rst_flags", 32'({busy, done, err}), 32'd0);
    step();
    reset = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].op == 0) do_load(vecs[v].data);
      else do_xfer(vecs[v].op == 1, vecs[v].data, vecs[v].delay);
    end

    // All three commands at once: only the read acts; commands while busy are dropped.
    read = 1'b1; write = 1'b1; mdr_in = 1'b1; bus_in = 32'h11111111;
    step();
    read = 1'b0; bus_in = 32'h22222222;
    @(negedge clk);
    check("prio_rd_req", 32'(mem_rd_req), 32'd1);
    check("prio_wr_req", 32'(mem_wr_req), 32'd0);
    check("prio_q", q, model_q);
    step();
    write = 1'b0; mdr_in = 1'b0;
    @(negedge clk);
    check("busy_wr_ignored", 32'(mem_wr_req), 32'd0);
    check("busy_load_ignored", q, model_q);
    check("busy_high", 32'(busy), 32'd1);
    // Ack together with a fresh read: the read lands in the wait state and is lost.
    sb.push_back(32'h77777777);
    mem_ack = 1'b1; mem_data_in = 32'h77777777; read = 1'b1;
    step();
    mem_ack = 1'b0; mem_data_in = '0; read = 1'b0;
    wait_done(4);
    model_q = 32'h77777777;
    @(negedge clk);
    check("ack_edge_read_dropped", 32'(mem_rd_req), 32'd0);
    step();

    // Stray ack while idle has no effect.
    mem_ack = 1'b1; mem_data_in = 32'h99999999;
    step();
    step();
    mem_ack = 1'b0; mem_data_in = '0;
    @(negedge clk);
    check("idle_ack_q", q, model_q);
    check("idle_ack_flags", 32'({done, busy, mem_rd_req, mem_wr_req}), 32'd0);
    step();

`ifdef MDR_TIMEOUT_EN
    // No ack: the request must give up after four wait cycles with a single err pulse.
    begin
      int hi;
      int errs;
      int dones;
      hi = 0; errs = 0; dones = 0;
      read = 1'b1;
      step();
      read = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_rd_req) hi++;
        if (err) errs++;
        if (done) dones++;
        step();
      end
      check("to_req_cycles", 32'(hi), 32'd4);
      check("to_err_pulses", 32'(errs), 32'd1);
      check("to_done", 32'(dones), 32'd0);
      check("to_q", q, model_q);
      check("to_busy", 32'(busy), 32'd0);
    end
    // Ack arriving on the expiring cycle wins.
    do_xfer(1'b1, 32'h0BADF00D, 3);
`else
    // Without the timeout feature a long-delayed ack still completes normally.
    do_xfer(1'b1, 32'h0BADF00D, 20);
`endif

    // Reset in the middle of a write: outputs clear at once, late ack is ignored.
    write = 1'b1;
    step();
    write = 1'b0;
    @(negedge clk);
    check("rst_pre_wr_req", 32'(mem_wr_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_q", q, 32'd0);
    step();
    reset = 1'b1;
    model_q = '0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_done", 32'(done), 32'd0);
    check("late_ack_state", 32'({busy, mem_rd_req, mem_wr_req}), 32'd0);
    check("late_ack_q", q, model_q);
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
